// File: rtl/rand_range_sampler.sv
// Uniform range sampler: slices a 64-bit random word into chunks,
// masks each to the bit-width of limit-1 and rejects values >= limit.
module rand_range_sampler #(
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             randomReady,
  input  logic [63:0]      randomValue,
  output logic             read,
  input  logic [CHUNK-1:0] limit,
  output logic             outValid,
  input  logic             outReady,
  output logic [CHUNK-1:0] outValue,
  output logic [15:0]      rejectCount
);

  localparam int N  = 64 / CHUNK;
  localparam int IW = $clog2(N);

  typedef enum logic [1:0] {
    EMPTY,
    EVAL,
    HOLD
  } state_t;

  state_t           state, state_d;
  logic [IW-1:0]    idx, idx_d;
  logic [63:0]      wordReg, word_d;
  logic             valid_d;
  logic [CHUNK-1:0] value_d;
  logic [15:0]      rej_d;

  logic [CHUNK-1:0] lm1, mask, chunk;
  logic             last, accept;

  // Smear limit-1 rightwards; limit=0 wraps to all ones.
  always_comb begin
    lm1  = limit - CHUNK'(1);
    mask = lm1;
    for (int s = 1; s < CHUNK; s = s * 2)
      mask = mask | (mask >> s);
  end

  assign chunk  = wordReg[idx*CHUNK +: CHUNK] & mask;
  assign last   = (idx == IW'(N - 1));
  assign accept = (limit == '0) || (chunk < limit);
  assign read   = rst && (state == EMPTY) && randomReady;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    word_d  = wordReg;
    valid_d = outValid;
    value_d = outValue;
    rej_d   = rejectCount;
    unique case (state)
      EMPTY: begin
        if (randomReady) begin
          word_d  = randomValue;
          idx_d   = '0;
          state_d = EVAL;
        end
      end
      EVAL: begin
        if (accept) begin
          value_d = chunk;
          valid_d = 1'b1;
          state_d = HOLD;
        end else begin
          if (rejectCount != 16'hFFFF)
            rej_d = rejectCount + 16'd1;
          if (last) begin
            state_d = EMPTY;
          end else begin
            idx_d = idx + IW'(1);
          end
        end
      end
      HOLD: begin
        if (outValid && outReady) begin
          valid_d = 1'b0;
          if (last) begin
            state_d = EMPTY;
          end else begin
            idx_d   = idx + IW'(1);
            state_d = EVAL;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= EMPTY;
      idx         <= '0;
      wordReg     <= '0;
      outValid    <= 1'b0;
      outValue    <= '0;
      rejectCount <= '0;
    end else begin
      state       <= state_d;
      idx         <= idx_d;
      wordReg     <= word_d;
      outValid    <= valid_d;
      outValue    <= value_d;
      rejectCount <= rej_d;
    end
  end

endmodule
